// File: rtl/routing_pkg.sv
// Shared routing-library types: arbiter FSM states and a one-hot helper.
package routing_pkg;

   localparam int MAX_S = 8;
   localparam int MAX_N = 2 ** MAX_S;

   typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_LOCK} state_t;

   function automatic logic [MAX_N-1:0] onehot_from_idx(input logic [MAX_S-1:0] idx);
      return MAX_N'(1) << idx;
   endfunction

endpackage

// File: rtl/rr_sel_arbiter_if.sv
// Request/select bus between the sources, the arbiter and the 2^S:1 mux.
interface rr_sel_arbiter_if #(parameter int S = 3);
   logic [2**S-1:0] req;
   logic [2**S-1:0] last;
   logic [S-1:0]    sel;
   logic [2**S-1:0] gnt;
   logic            valid;
   logic            ready;

   // master: the arbiter; slave: sources plus downstream consumer
   modport master (input req, last, ready, output sel, gnt, valid);
   modport slave  (output req, last, ready, input sel, gnt, valid);
endinterface

// File: rtl/rr_prio_enc.sv
// Rotating priority encoder: first set req bit at or after ptr, wrapping.
module rr_prio_enc #(
   parameter int S = 3
) (
   input  logic [2**S-1:0] req,
   input  logic [S-1:0]    ptr,
   output logic [S-1:0]    idx,
   output logic            any
);
   localparam int N = 2 ** S;

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic [S-1:0]   off;

   always_comb begin
      dbl = {req, req};
      // rot[j] is req[(ptr + j) mod N]
      rot = dbl[ptr +: N];
      off = '0;
      for (int j = N - 1; j >= 0; j--)
         if (rot[j]) off = S'(j);
      any = |req;
      idx = ptr + off;
   end
endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter driving the binary select of a 2^S:1 mux.
// Define RR_ARB_LOCK_EN to hold the grant across multi-beat packets (last-terminated).
module rr_sel_arbiter
   import routing_pkg::*;
#(
   parameter int S = 3
) (
   input logic               clk,
   input logic               rst,
   rr_sel_arbiter_if.master  bus
);
   localparam int N = 2 ** S;

   state_t         state;
   logic [S-1:0]   ptr;
   logic [S-1:0]   sel_q;
   logic [N-1:0]   gnt_q;
   logic           valid_q;
   logic [S-1:0]   base;
   logic [S-1:0]   win;
   logic           win_any;
   logic           hold_pkt;

   // While granted, the only arbitration that matters is the one taken at
   // handshake, which must start just past the served input.
   assign base = (state == ST_IDLE) ? ptr : sel_q + S'(1);

   rr_prio_enc #(.S(S)) u_enc (
      .req (bus.req),
      .ptr (base),
      .idx (win),
      .any (win_any)
   );

`ifdef RR_ARB_LOCK_EN
   assign hold_pkt = !bus.last[sel_q];
`else
   logic unused_last;
   assign unused_last = ^bus.last;
   assign hold_pkt    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         ptr     <= '0;
         sel_q   <= '0;
         gnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (win_any) begin
                  sel_q   <= win;
                  gnt_q   <= N'(onehot_from_idx(MAX_S'(win)));
                  valid_q <= 1'b1;
                  state   <= ST_GRANT;
               end
            end
            default: begin
               // GRANT and LOCK share the handshake path; LOCK only differs
               // in that a non-final beat keeps the current source.
               if (bus.ready) begin
                  if (hold_pkt) begin
                     state <= ST_LOCK;
                  end else begin
                     ptr <= sel_q + S'(1);
                     if (win_any) begin
                        sel_q <= win;
                        gnt_q <= N'(onehot_from_idx(MAX_S'(win)));
                        state <= ST_GRANT;
                     end else begin
                        gnt_q   <= '0;
                        valid_q <= 1'b0;
                        state   <= ST_IDLE;
                     end
                  end
               end
            end
         endcase
      end
   end

   assign bus.sel   = sel_q;
   assign bus.gnt   = gnt_q;
   assign bus.valid = valid_q;
endmodule
